// File: rtl/tick_gen.sv
// tick_gen: programmable one-cycle clock-enable generator with periodic/one-shot modes
// and a shadowed divisor. Defining TICKGEN_AUTOSTART_EN makes the block leave reset
// already running in periodic mode, like the legacy free-running 1 Hz enable.
module tick_gen #(
    parameter int FREQ = 50_000_000,
    parameter int W    = $clog2(FREQ + 1)
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic         stop,
    input  logic         oneshot,
    input  logic         div_load,
    input  logic [W-1:0] div_in,
    output logic         tick,
    output logic         busy,
    output logic         div_err
);
    typedef enum logic {IDLE, RUN} state_t;

`ifdef TICKGEN_AUTOSTART_EN
    localparam state_t RST_STATE = RUN;
    localparam logic   RST_BUSY  = 1'b1;
`else
    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_BUSY  = 1'b0;
`endif
    localparam logic [W-1:0] DIV_RST = W'(FREQ);

    state_t         state, next_state;
    logic [W-1:0]   cnt, cnt_d;
    logic [W-1:0]   div_act, div_d;
    logic [W-1:0]   pend_div, pend_d;
    logic           pend_valid, pv_d;
    logic           mode, mode_d;
    logic           tick_d, busy_d, err_d;
    logic           running, do_start, tc, load_ok;

    // stop dominates start; a start or stop edge never produces a tick
    assign running  = state == RUN;
    assign do_start = start && !stop;
    assign tc       = running && !start && !stop && cnt == div_act - W'(1);
    assign load_ok  = div_load && div_in != '0;

    // state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= RST_STATE;
        else        state <= next_state;
    end

    // next-state: stop > start > one-shot completion
    always_comb begin
        next_state = state;
        if (stop)                next_state = IDLE;
        else if (do_start)       next_state = RUN;
        else if (tc && mode)     next_state = IDLE;
    end

    // next values of the registered outputs
    always_comb begin
        tick_d = tc;
        busy_d = next_state == RUN;
        err_d  = div_load && div_in == '0;
    end

    // counter, mode capture and divisor shadowing
    always_comb begin
        cnt_d  = (stop || start || !running || tc) ? '0 : cnt + W'(1);
        mode_d = do_start ? oneshot : mode;
        div_d  = div_act;
        pend_d = pend_div;
        pv_d   = pend_valid;
        if (load_ok && (!running || start || stop)) begin
            div_d = div_in;
            pv_d  = 1'b0;
        end else if (start || stop) begin
            div_d = pend_valid ? pend_div : div_act;
            pv_d  = 1'b0;
        end else if (tc) begin
            div_d  = pend_valid ? pend_div : div_act;
            pend_d = load_ok ? div_in : pend_div;
            pv_d   = load_ok;
        end else if (load_ok) begin
            pend_d = div_in;
            pv_d   = 1'b1;
        end
    end

    // datapath and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt        <= '0;
            div_act    <= DIV_RST;
            pend_div   <= '0;
            pend_valid <= 1'b0;
            mode       <= 1'b0;
            tick       <= 1'b0;
            busy       <= RST_BUSY;
            div_err    <= 1'b0;
        end else begin
            cnt        <= cnt_d;
            div_act    <= div_d;
            pend_div   <= pend_d;
            pend_valid <= pv_d;
            mode       <= mode_d;
            tick       <= tick_d;
            busy       <= busy_d;
            div_err    <= err_d;
        end
    end
endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed vector table plus hand sequences for tick_gen at FREQ=5, W=3.
module tb_tick_gen;
    localparam int FREQ = 5;
    localparam int W    = 3;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0, stop = 1'b0, oneshot = 1'b0, div_load = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         tick, busy, div_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic         s, p, o, l;
        logic [W-1:0] d;
        logic         t, b, e;
    } vec_t;
    vec_t vecs[$];

    tick_gen #(.FREQ(FREQ), .W(W)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .stop(stop), .oneshot(oneshot),
        .div_load(div_load), .div_in(div_in), .tick(tick), .busy(busy), .div_err(div_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic p, input logic o, input logic l, input logic [W-1:0] d);
        start = s; stop = p; oneshot = o; div_load = l; div_in = d;
        @(posedge clk);
        #1;
        start = 0; stop = 0; oneshot = 0; div_load = 0; div_in = '0;
    endtask

    task automatic add(input logic s, input logic p, input logic o, input logic l, input logic [W-1:0] d,
                       input logic t, input logic b, input logic e);
        vecs.push_back('{s, p, o, l, d, t, b, e});
    endtask

    task automatic idle(input int n, input logic b);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0, b, 0);
    endtask

    initial begin
        #12;
        check("rst_tick", tick, 0);
        check("rst_err", div_err, 0);
        check("rst_div", dut.div_act, FREQ);
`ifdef TICKGEN_AUTOSTART_EN
        check("rst_busy_auto", busy, 1);
        @(negedge clk) n_rst = 1;
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 0, 0, 0);
            check($sformatf("auto_e%0d_tick", k), tick, k == 5);
            check($sformatf("auto_e%0d_busy", k), busy, 1);
        end
        step(0, 1, 0, 1, 1);
        check("auto_stop_busy", busy, 0);
        check("auto_div1", dut.div_act, 1);
        step(1, 0, 0, 0, 0);
        check("auto_restart_tick", tick, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0, 0);
            check($sformatf("auto_div1_tick%0d", k), tick, 1);
        end
`else
        check("rst_busy", busy, 0);
        @(negedge clk) n_rst = 1;
        // periodic at 5, shadowed reload to 3, illegal loads, stop with direct load, one-shot
        add(1, 0, 0, 0, 0, 0, 1, 0);
        idle(4, 1);
        add(0, 0, 0, 0, 0, 1, 1, 0);
        idle(4, 1);
        add(0, 0, 0, 0, 0, 1, 1, 0);
        idle(1, 1);
        add(0, 0, 0, 1, 3, 0, 1, 0);
        idle(2, 1);
        add(0, 0, 0, 0, 0, 1, 1, 0);
        idle(2, 1);
        add(0, 0, 0, 0, 0, 1, 1, 0);
        idle(2, 1);
        add(0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1, 1);
        idle(1, 1);
        add(0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 1, 0, 1, 5, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1);
        idle(1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 0);
        idle(4, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0);
        foreach (vecs[i]) begin
            step(vecs[i].s, vecs[i].p, vecs[i].o, vecs[i].l, vecs[i].d);
            check($sformatf("v%0d_tick", i), tick, vecs[i].t);
            check($sformatf("v%0d_busy", i), busy, vecs[i].b);
            check($sformatf("v%0d_err", i), div_err, vecs[i].e);
        end
        check("div_after_stop_load", dut.div_act, 5);
        begin
            int ticks = 0;
            for (int k = 0; k < 20; k++) begin
                step(0, 0, 0, 0, 0);
                ticks += int'(tick) + int'(busy);
            end
            check("oneshot_quiet_20", ticks, 0);
        end
        // restart in RUN abandons the current period
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("restart_tick", tick, 0);
        check("restart_cnt", dut.cnt, 0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 0, 0, 0);
            check($sformatf("restart_e%0d_tick", k), tick, k == 5);
        end
        // start and stop together at terminal count: stop wins, no tick
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0);
        check("pre_ss_cnt", dut.cnt, 4);
        step(1, 1, 0, 0, 0);
        check("ss_tick", tick, 0);
        check("ss_busy", busy, 0);
        check("ss_cnt", dut.cnt, 0);
        // asynchronous reset mid-period discards a pending divisor
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3);
        step(0, 0, 0, 1, 0);
        check("pre_rst_pend", dut.pend_valid, 1);
        check("pre_rst_err", div_err, 1);
        #2 n_rst = 0;
        #1;
        check("arst_tick", tick, 0);
        check("arst_busy", busy, 0);
        check("arst_err", div_err, 0);
        check("arst_div", dut.div_act, 5);
        check("arst_pend", dut.pend_valid, 0);
        check("arst_cnt", dut.cnt, 0);
        @(negedge clk) n_rst = 1;
        step(0, 0, 0, 0, 0);
        check("post_rst_busy", busy, 0);
        // divisor of 1: continuous in periodic, single pulse in one-shot
        step(0, 0, 0, 1, 1);
        check("div1_loaded", dut.div_act, 1);
        step(1, 0, 0, 0, 0);
        check("div1_start_tick", tick, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 0, 0, 0);
            check($sformatf("div1_tick%0d", k), tick, 1);
        end
        step(0, 1, 0, 0, 0);
        check("div1_stop_tick", tick, 0);
        step(1, 0, 1, 0, 0);
        check("div1_os_busy", busy, 1);
        step(0, 0, 0, 0, 0);
        check("div1_os_tick", tick, 1);
        check("div1_os_busy_fall", busy, 0);
        step(0, 0, 0, 0, 0);
        check("div1_os_tick_end", tick, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tick_gen.md
Name: tick_gen

Overview:
- Parametrised, run-time programmable clock-enable (tick) generator. It is the successor to the fixed 1 Hz enable counter.
- Produces a one-cycle `tick` every DIV clocks, in periodic or one-shot mode, with start/stop control.
- Divisor changes are glitch-free: they are shadowed until the next period boundary.
- Sits beside slow peripherals (display scan, debouncers, timers) and gates their updates from the single system clock.

Parameters:
- FREQ, 50_000_000: reset value of the divisor (input clock in Hz, so the reset setting gives 1 tick/s).
- W, $clog2(FREQ+1): width of the divisor and counter. Must satisfy 2**W-1 >= FREQ.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  pulse: start or restart counting.
- stop  in  1  pulse: halt counting.
- oneshot  in  1  mode, sampled on the start edge. 1 = single tick then halt; 0 = periodic.
- div_load  in  1  pulse: load div_in.
- div_in  in  W  requested divisor. Legal range is 1..2**W-1.
- tick  out  1  registered, high for exactly one cycle per period.
- busy  out  1  registered, high while in RUN.
- div_err  out  1  registered, one-cycle pulse when div_load is given with div_in==0.

Behaviour:
- Reset is asynchronous on n_rst=0. Reset values:
  - state=IDLE, cnt=0, div_act=FREQ, pend_valid=0, mode=periodic;
  - tick=0, busy=0, div_err=0.
- States:
  - IDLE: cnt held at 0, tick=0.
  - RUN: cnt increments by 1 per edge.
- Counting in RUN: at an edge where cnt==div_act-1, all of the following happen on that edge:
  - cnt<=0 and tick<=1;
  - a pending divisor is applied;
  - in one-shot mode, state<=IDLE and busy<=0.
  - At every other edge, tick<=0.
- Latency: start is sampled at edge E0. The first tick is high in the cycle after edge E(div_act), with period div_act thereafter.
- div_act==1: tick is high continuously in periodic mode. In one-shot mode it is a single pulse one cycle after the start edge.
- start in IDLE: cnt<=0, mode<=oneshot, state<=RUN, busy<=1.
- start in RUN: restart with the same effect. The period in progress is abandoned and no tick is produced on that edge.
- stop: state<=IDLE, cnt<=0, busy<=0. No tick on that edge, even at terminal count.
- start and stop on the same edge: stop wins.
- div_load with div_in==0:
  - ignored; div_act and pend unchanged;
  - div_err<=1 for one cycle.
- div_load with a legal div_in:
  - In IDLE: div_act<=div_in immediately.
  - In RUN: pend_div<=div_in, pend_valid<=1. Applied (div_act<=pend_div, pend_valid<=0) at the next terminal-count edge, or on start/stop, whichever comes first.
  - A later load overwrites an earlier pending value.
- div_load coinciding with a terminal-count edge: the new value becomes pending and applies at the following boundary. The value already pending is applied on this edge.
- div_load coinciding with start or stop: div_in is applied directly to div_act on that edge.
- Arithmetic: cnt is W bits and compares against div_act-1. cnt never exceeds div_act-1, so it never wraps.

Optional Feature:
- Macro name: TICKGEN_AUTOSTART_EN.
- Defined:
  - reset puts state=RUN, busy=1, mode=periodic, cnt=0;
  - the first tick is high after edge E(FREQ) following reset release;
  - start/stop/div_load behave as above.
  - This is the drop-in replacement for the legacy free-running 1 Hz enable.
- Undefined: the block resets to IDLE and stays there until start.

Test Plan (FREQ=5, W=3 unless noted):
- Reset release, start pulse with oneshot=0 -> busy=1 next cycle; tick high 5 cycles after the start edge, then every 5 cycles, each pulse exactly 1 cycle wide.
- start with oneshot=1 -> a single tick 5 cycles after start; busy falls on the same edge tick rises; no further ticks over 20 cycles.
- Periodic run, div_load div_in=3 two cycles after a tick -> the next tick still comes at 5 cycles; subsequent ticks every 3 cycles.
- div_load div_in=0 in IDLE and in RUN -> div_err one-cycle pulse each time; tick period unchanged at 5.
- start and stop on the same edge while running at cnt==4 -> no tick, busy=0, cnt=0. Then n_rst pulsed low mid-period -> all outputs 0 immediately, div_act back to 5.
- Build with TICKGEN_AUTOSTART_EN -> busy=1 out of reset, with no start pulse; first tick after edge 5 following reset release; div_in=1 load then stop/start -> tick continuously high.
